// File: rtl/priority_encoder_scan.sv
// Sequential priority encoder: accepts a request vector, then emits the index
// of every set bit, one beat per transfer, MSB-first or LSB-first.
module priority_encoder_scan #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] D,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] B,
    output logic             out_last,
    output logic             out_zero,
    output logic [CNT_W-1:0] count
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;

    logic [IDX_W-1:0] idx;
    logic             single;
    logic [CNT_W-1:0] popcnt;
    logic             accept, xfer;

    // Winner search over the registered vector only; D never reaches B.
    always_comb begin
        idx = '0;
        if (!mode_q) begin
            for (int i = 0; i < WIDTH; i++)
                if (pend_q[i]) idx = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (pend_q[i]) idx = IDX_W'(i);
        end
    end

    // At most one bit left: clearing the lowest set bit leaves nothing.
    assign single = ((pend_q & (pend_q - WIDTH'(1))) == '0);

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < WIDTH; i++)
            popcnt = popcnt + CNT_W'(D[i]);
    end

    assign out_valid = (state_q == SCAN);
    assign B         = out_valid ? idx : '0;
    assign out_last  = out_valid & single;
    assign out_zero  = zero_q;
    assign count     = count_q;

    assign xfer     = out_valid & out_ready;
    assign in_ready = (state_q == IDLE) | (xfer & out_last);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        count_d = count_q;
        zero_d  = zero_q;
        if (accept) begin
            // Also covers back-to-back: a new vector replaces the finished one.
            state_d = SCAN;
            pend_d  = D;
            mode_d  = mode;
            count_d = popcnt;
            zero_d  = (D == '0);
        end else if (xfer) begin
            pend_d = pend_q & ~(WIDTH'(1) << idx);
            if (single) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_scan.sv
// Directed bench for priority_encoder_scan: table of single-burst vectors plus
// hand sequences for stall, back-to-back, WIDTH=5 and mid-burst reset.
module tb_priority_encoder_scan;

    logic       clk = 1'b0;
    logic       rst_n, rst5_n;
    logic       in_valid, mode, out_ready;
    logic [7:0] d;
    logic       in_ready, out_valid, out_last, out_zero;
    logic [2:0] b;
    logic [3:0] cnt;

    logic       in_valid5, mode5, out_ready5;
    logic [4:0] d5;
    logic       in_ready5, out_valid5, out_last5, out_zero5;
    logic [2:0] b5;
    logic [2:0] cnt5;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    priority_encoder_scan #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .D(d), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .B(b), .out_last(out_last), .out_zero(out_zero), .count(cnt)
    );

    priority_encoder_scan #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst5_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .D(d5), .mode(mode5), .out_valid(out_valid5), .out_ready(out_ready5),
        .B(b5), .out_last(out_last5), .out_zero(out_zero5), .count(cnt5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       m;
        int         nb;
        int         bx[4];
        int         c;
        logic       z;
    } vec_t;

    function automatic vec_t mk(logic [7:0] dv, logic m, int nb, int b0, int b1,
                                int b2, int b3, int c, logic z);
        vec_t v;
        v.d = dv; v.m = m; v.nb = nb; v.c = c; v.z = z;
        v.bx[0] = b0; v.bx[1] = b1; v.bx[2] = b2; v.bx[3] = b3;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = mk(8'hA5, 1'b0, 4, 7, 5, 2, 0, 4, 1'b0);
        vecs[1] = mk(8'hA5, 1'b1, 4, 0, 2, 5, 7, 4, 1'b0);
        vecs[2] = mk(8'h00, 1'b0, 1, 0, 0, 0, 0, 0, 1'b1);
        vecs[3] = mk(8'h80, 1'b1, 1, 7, 0, 0, 0, 1, 1'b0);
        vecs[4] = mk(8'h01, 1'b0, 1, 0, 0, 0, 0, 1, 1'b0);
        vecs[5] = mk(8'h18, 1'b0, 2, 4, 3, 0, 0, 2, 1'b0);

        rst_n = 1'b0; rst5_n = 1'b0;
        in_valid = 0; mode = 0; out_ready = 1; d = '0;
        in_valid5 = 0; mode5 = 0; out_ready5 = 1; d5 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_B", b, 0);
        chk("rst_last", out_last, 0);
        chk("rst_count", cnt, 0);
        chk("rst_zero", out_zero, 0);
        rst_n = 1'b1; rst5_n = 1'b1;
        @(negedge clk);

        // Table: one burst per vector, out_ready held high.
        for (int v = 0; v < 6; v++) begin
            d = vecs[v].d; mode = vecs[v].m; in_valid = 1;
            #1 chk("accept_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 0; d = 8'h5A; mode = ~vecs[v].m;
            for (int j = 0; j < vecs[v].nb; j++) begin
                #1;
                chk("beat_valid", out_valid, 1);
                chk("beat_B", b, vecs[v].bx[j]);
                chk("beat_last", out_last, (j == vecs[v].nb - 1));
                chk("beat_count", cnt, vecs[v].c);
                chk("beat_zero", out_zero, vecs[v].z);
                chk("beat_in_ready", in_ready, (j == vecs[v].nb - 1));
                @(negedge clk);
            end
            #1 chk("post_valid", out_valid, 0);
        end

        // Stall: FF, out_ready low for 3 cycles, competing in_valid ignored.
        @(negedge clk);
        d = 8'hFF; mode = 0; in_valid = 1;
        @(negedge clk);
        d = 8'h0F; out_ready = 0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_B", b, 7);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_count", cnt, 8);
            @(negedge clk);
        end
        out_ready = 1; in_valid = 0;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("ff_B", b, 7 - j);
            chk("ff_last", out_last, (j == 7));
            chk("ff_count", cnt, 8);
            @(negedge clk);
        end
        #1 chk("ff_done", out_valid, 0);

        // Back-to-back: 81 then 10 (LSB-first) offered on the last beat.
        @(negedge clk);
        d = 8'h81; mode = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        #1 chk("b2b_B0", b, 7);
        chk("b2b_last0", out_last, 0);
        @(negedge clk);
        d = 8'h10; mode = 1; in_valid = 1;
        #1 chk("b2b_B1", b, 0);
        chk("b2b_last1", out_last, 1);
        chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1 chk("b2b_valid2", out_valid, 1);
        chk("b2b_B2", b, 4);
        chk("b2b_last2", out_last, 1);
        chk("b2b_count2", cnt, 1);
        @(negedge clk);
        #1 chk("b2b_done", out_valid, 0);

        // WIDTH=5 single beat, then reset mid-burst.
        d5 = 5'b10000; in_valid5 = 1;
        @(negedge clk);
        in_valid5 = 0;
        #1 chk("w5_B", b5, 4);
        chk("w5_last", out_last5, 1);
        chk("w5_count", cnt5, 1);
        @(negedge clk);
        d5 = 5'b11111; in_valid5 = 1;
        @(negedge clk);
        in_valid5 = 0;
        #1 chk("w5f_B", b5, 4);
        chk("w5f_count", cnt5, 5);
        #1 rst5_n = 1'b0;
        #1 chk("w5rst_valid", out_valid5, 0);
        chk("w5rst_in_ready", in_ready5, 1);
        chk("w5rst_count", cnt5, 0);
        @(negedge clk);
        rst5_n = 1'b1;
        @(negedge clk);
        #1 chk("w5rst_stays_idle", out_valid5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/priority_encoder_scan.md
Name: priority_encoder_scan

Overview:
Parametrised, sequential successor to the 8-to-3 priority encoder. It accepts a WIDTH-bit request vector through a valid/ready handshake. It then emits the index of every set bit, one per output beat, in priority order. Priority direction is selectable per vector: MSB-first or LSB-first. Used wherever all active lines must be serviced in turn, not just the winner: interrupt scanning, multi-hit decode, arbitration queues.

Parameters:
WIDTH, 8, request vector width; legal range 2..256; need not be a power of two.
IDX_W, $clog2(WIDTH), index width; derived, never overridden.
CNT_W, $clog2(WIDTH+1), set-bit count width; derived, never overridden.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  D and mode are valid
in_ready  output  1  block can accept a vector this cycle
D  input  WIDTH  request vector; D[i] set = line i active
mode  input  1  0 = MSB-first (D[WIDTH-1] highest priority), 1 = LSB-first (D[0] highest)
out_valid  output  1  B/out_last/out_zero/count valid
out_ready  input  1  consumer accepts the current beat
B  output  IDX_W  index of current highest-priority pending bit
out_last  output  1  current beat is the final beat of the vector
out_zero  output  1  accepted vector was all-zero
count  output  CNT_W  number of set bits in the accepted vector, held for the whole burst

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, pending register 0, mode_r 0, count 0, out_zero 0. Outputs: in_ready 1, out_valid 0, B 0, out_last 0. Reset mid-burst abandons the remaining beats with no further output.
- States: IDLE, SCAN.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch D into pending, mode into mode_r, popcount(D) into count. Set out_zero = (D==0). Go to SCAN.
- SCAN:
  - out_valid = 1.
  - B = index of the highest set bit of pending (mode_r=0) or the lowest set bit (mode_r=1).
  - out_last = 1 when pending has at most one bit set.
  - B and out_last are combinational from registered pending/mode_r only; there is no path from D.
- Output handshake: a beat transfers on out_valid & out_ready.
  - On transfer, clear bit B in pending.
  - If out_last, leave SCAN.
  - While out_valid & !out_ready, B/out_last/out_zero/count stay stable.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready to in_ready, by design.
- Back-to-back: if in_valid is high in the same cycle as the last beat's transfer, the new vector is latched and SCAN continues with no idle cycle. Otherwise go to IDLE.
- Latency: first beat is visible the cycle after acceptance. A vector with k set bits takes k beats, minimum 1.
- All-zero vector: exactly one beat with B=0, out_zero=1, out_last=1, count=0.
- mode and D are sampled only at acceptance. Changes during SCAN are ignored.
- Non-power-of-two WIDTH: B never exceeds WIDTH-1. count reaches WIDTH when all bits are set (e.g. WIDTH=8 gives 4'd8).
- in_valid while in_ready=0 is ignored; the source must hold its data.

Test Plan:
1. WIDTH=8, D=8'b1010_0101, mode=0, out_ready=1 -> B=7,5,2,0 on four consecutive cycles; out_last only on B=0; count=4 throughout; in_ready high on the fourth beat.
2. Same D, mode=1 -> B=0,2,5,7; out_last on B=7.
3. D=8'h00 -> one beat B=0, out_zero=1, out_last=1, count=0; next cycle out_valid=0.
4. D=8'hFF, mode=0, out_ready low for 3 cycles after the first beat -> B held at 7 and in_ready=0 during the stall. A concurrent in_valid is not accepted. Eight beats total (7..0), count=8.
5. Back-to-back: D=8'h81, then D=8'h10 (mode=1) presented during the last beat -> B=7,0,4 with out_valid continuously high; the second vector has out_last=1 on B=4.
6. WIDTH=5, D=5'b10000 -> single beat B=3'd4, out_last=1, count=1. Assert rst_n low mid-burst of 5'b11111 -> out_valid drops to 0 immediately and in_ready=1.
